// File: rtl/lock_pkg.sv
// Shared types and default constants for the canal lock sequencer.
// Holds the FSM state enum, the direction enum and the default geometry.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ENTRY,
        XFER,
        EXIT
    } state_t;

    typedef enum logic {
        DIR_ARRIVE,
        DIR_DEPART
    } dir_t;

    localparam int LEVEL_MAX_DEF    = 15;
    localparam int LVL_W_DEF        = 4;
    localparam int GATE_TIMEOUT_DEF = 255;

endpackage

// File: rtl/lock_level_counter.sv
// Saturating up/down chamber level model with a reached-target flag.
// Ports: clk, rst, i_up, i_down, i_target in; o_level, o_at_target out.
module lock_level_counter #(
    parameter int LEVEL_MAX = 15,
    parameter int LVL_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_up,
    input  logic             i_down,
    input  logic [LVL_W-1:0] i_target,
    output logic [LVL_W-1:0] o_level,
    output logic             o_at_target
);

    logic [LVL_W-1:0] r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (i_up && (r_level < LVL_W'(LEVEL_MAX))) begin
            r_level <= r_level + 1'b1;
        end else if (i_down && (r_level != '0)) begin
            r_level <= r_level - 1'b1;
        end
    end

    assign o_level     = r_level;
    assign o_at_target = (r_level == i_target);

endmodule

// File: rtl/lock_sequencer.sv
// Canal lock sequencer: request latches, round-robin arbiter and lock FSM.
// Ports: clk, rst, arrive_req, depart_req, boat_clear in; gate enables,
// valves, water_level, pend_arrive/depart, busy, timeout out.
// Optional macro LOCK_GATE_TIMEOUT_EN adds an entry-gate timeout.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int LEVEL_MAX    = LEVEL_MAX_DEF,
    parameter int LVL_W        = LVL_W_DEF,
    parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_req,
    input  logic             depart_req,
    input  logic             boat_clear,
    output logic             outer_gate_open,
    output logic             inner_gate_open,
    output logic             fill_valve,
    output logic             drain_valve,
    output logic [LVL_W-1:0] water_level,
    output logic             pend_arrive,
    output logic             pend_depart,
    output logic             busy,
    output logic             timeout
);

    state_t           r_state;
    state_t           w_next;
    dir_t             r_dir;
    dir_t             r_last;
    logic             r_pend_a;
    logic             r_pend_d;
    logic             r_timeout;
    logic             w_acc_a;
    logic             w_acc_d;
    logic             w_to;
    logic             w_move;
    logic             w_at_tgt;
    logic [LVL_W-1:0] w_level;
    logic [LVL_W-1:0] w_entry_lvl;
    logic [LVL_W-1:0] w_exit_lvl;
    logic [LVL_W-1:0] w_target;

`ifdef LOCK_GATE_TIMEOUT_EN
    logic [7:0] r_tcnt;
    logic       w_tcnt_hit;
    assign w_tcnt_hit = (r_tcnt == 8'(GATE_TIMEOUT - 1));
`else
    logic       w_tcnt_hit;
    logic [7:0] w_unused_to;
    assign w_tcnt_hit  = 1'b0;
    assign w_unused_to = 8'(GATE_TIMEOUT);
`endif

    assign w_entry_lvl = (r_dir == DIR_ARRIVE) ? LVL_W'(LEVEL_MAX) : '0;
    assign w_exit_lvl  = (r_dir == DIR_ARRIVE) ? '0 : LVL_W'(LEVEL_MAX);
    assign w_target    = ((r_state == XFER) || (r_state == EXIT)) ?
                         w_exit_lvl : w_entry_lvl;
    assign w_move      = (r_state == PREP) || (r_state == XFER);

    lock_level_counter #(
        .LEVEL_MAX (LEVEL_MAX),
        .LVL_W     (LVL_W)
    ) u_level (
        .clk         (clk),
        .rst         (rst),
        .i_up        (fill_valve),
        .i_down      (drain_valve),
        .i_target    (w_target),
        .o_level     (w_level),
        .o_at_target (w_at_tgt)
    );

    // Next state and arbitration
    always_comb begin
        w_next  = r_state;
        w_acc_a = 1'b0;
        w_acc_d = 1'b0;
        w_to    = 1'b0;
        case (r_state)
            IDLE: begin
                // Arrival wins a tie unless it was served last
                if (r_pend_a && (!r_pend_d || (r_last == DIR_DEPART))) begin
                    w_acc_a = 1'b1;
                    w_next  = PREP;
                end else if (r_pend_d) begin
                    w_acc_d = 1'b1;
                    w_next  = PREP;
                end
            end
            PREP: if (w_at_tgt) w_next = ENTRY;
            ENTRY: begin
                if (boat_clear) begin
                    w_next = XFER;
                end else if (w_tcnt_hit) begin
                    w_next = IDLE;
                    w_to   = 1'b1;
                end
            end
            XFER: if (w_at_tgt) w_next = EXIT;
            EXIT: if (boat_clear) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state and level only
    always_comb begin
        outer_gate_open = 1'b0;
        inner_gate_open = 1'b0;
        fill_valve      = w_move && (w_level < w_target);
        drain_valve     = w_move && (w_level > w_target);
        if (r_state == ENTRY) begin
            outer_gate_open = (r_dir == DIR_ARRIVE);
            inner_gate_open = (r_dir == DIR_DEPART);
        end else if (r_state == EXIT) begin
            outer_gate_open = (r_dir == DIR_DEPART);
            inner_gate_open = (r_dir == DIR_ARRIVE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dir     <= DIR_ARRIVE;
            r_last    <= DIR_DEPART;
            r_pend_a  <= 1'b0;
            r_pend_d  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_to;
            // A request on the accepting edge is re-latched
            r_pend_a  <= arrive_req | (r_pend_a & ~w_acc_a);
            r_pend_d  <= depart_req | (r_pend_d & ~w_acc_d);
            if (w_acc_a) begin
                r_dir  <= DIR_ARRIVE;
                r_last <= DIR_ARRIVE;
            end else if (w_acc_d) begin
                r_dir  <= DIR_DEPART;
                r_last <= DIR_DEPART;
            end
        end
    end

`ifdef LOCK_GATE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state != ENTRY) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end
    assign timeout = r_timeout;
`else
    logic w_unused_rto;
    assign w_unused_rto = r_timeout;
    assign timeout      = 1'b0;
`endif

    assign water_level = w_level;
    assign pend_arrive = r_pend_a;
    assign pend_depart = r_pend_d;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: vector table, directed
// corner sequences and a random run against a phase-based model.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arrive_req = 1'b0;
    logic       depart_req = 1'b0;
    logic       boat_clear = 1'b0;
    logic       outer_gate_open, inner_gate_open;
    logic       fill_valve, drain_valve;
    logic [3:0] water_level;
    logic       pend_arrive, pend_depart, busy, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    lock_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .arrive_req      (arrive_req),
        .depart_req      (depart_req),
        .boat_clear      (boat_clear),
        .outer_gate_open (outer_gate_open),
        .inner_gate_open (inner_gate_open),
        .fill_valve      (fill_valve),
        .drain_valve     (drain_valve),
        .water_level     (water_level),
        .pend_arrive     (pend_arrive),
        .pend_depart     (pend_depart),
        .busy            (busy),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    // {outer, inner, fill, drain, pa, pd, busy, timeout, level}
    function automatic logic [11:0] obs();
        return {outer_gate_open, inner_gate_open, fill_valve,
                drain_valve, pend_arrive, pend_depart, busy,
                timeout, water_level};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 level to entry, 2 entry open,
    //        3 level to exit, 4 exit open
    int m_ph, m_lvl, m_tc;
    bit m_pa, m_pd, m_arr, m_last_arr, m_to;

    function automatic void model_reset();
        m_ph = 0; m_lvl = 0; m_tc = 0;
        m_pa = 0; m_pd = 0; m_arr = 0; m_last_arr = 0; m_to = 0;
    endfunction

    function automatic void model_edge(bit a, bit d, bit bc);
        int ent = m_arr ? 15 : 0;
        int ext = m_arr ? 0 : 15;
        int old = m_ph;
        m_to = 0;
        case (m_ph)
            0: if (m_pa || m_pd) begin
                m_arr = m_pa && (!m_pd || !m_last_arr);
                m_last_arr = m_arr;
                if (m_arr) m_pa = 0; else m_pd = 0;
                m_ph = 1;
            end
            1: if (m_lvl == ent) m_ph = 2;
               else m_lvl += (ent > m_lvl) ? 1 : -1;
            2: begin
                if (bc) m_ph = 3;
`ifdef LOCK_GATE_TIMEOUT_EN
                else if (m_tc == 254) begin m_ph = 0; m_to = 1; end
`endif
            end
            3: if (m_lvl == ext) m_ph = 4;
               else m_lvl += (ext > m_lvl) ? 1 : -1;
            4: if (bc) m_ph = 0;
            default: m_ph = 0;
        endcase
        m_tc = (old == 2 && m_ph == 2) ? m_tc + 1 : 0;
        m_pa |= a;
        m_pd |= d;
    endfunction

    function automatic logic [11:0] model_out();
        int tgt = (m_ph >= 3) ? (m_arr ? 0 : 15) : (m_arr ? 15 : 0);
        bit mv = (m_ph == 1 || m_ph == 3);
        bit o = (m_ph == 2 && m_arr) || (m_ph == 4 && !m_arr);
        bit i = (m_ph == 2 && !m_arr) || (m_ph == 4 && m_arr);
        bit f = mv && (m_lvl < tgt);
        bit dr = mv && (m_lvl > tgt);
        return {o, i, f, dr, m_pa, m_pd, m_ph != 0, m_to, 4'(m_lvl)};
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge(arrive_req, depart_req, boat_clear);
        #1;
    endtask

    task automatic do_reset();
        arrive_req = 0; depart_req = 0; boat_clear = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        logic a, d, bc;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int cnt, tocnt, lim;
        bit ok, first_outer, seen_gate;

        tbl[0] = '{0, 0, 1, 12'b0000_0000_0000};
        tbl[1] = '{0, 1, 0, 12'b0000_0100_0000};
        tbl[2] = '{0, 0, 1, 12'b0000_0010_0000};
        tbl[3] = '{0, 0, 1, 12'b0100_0010_0000};
        tbl[4] = '{0, 0, 0, 12'b0100_0010_0000};
        tbl[5] = '{0, 0, 1, 12'b0010_0010_0000};
        tbl[6] = '{0, 0, 0, 12'b0010_0010_0001};
        tbl[7] = '{0, 0, 0, 12'b0010_0010_0010};
        tbl[8] = '{1, 0, 0, 12'b0010_1010_0011};

        // reset state
        rst = 1;
        #1;
        chk("reset_async", int'(obs()), 0);
        @(posedge clk); #1;
        chk("reset_state", int'(obs()), 0);
        rst = 0;
        model_reset();

        // table: depart at level 0, boat_clear in IDLE/PREP ignored
        for (int i = 0; i < 9; i++) begin
            arrive_req = tbl[i].a;
            depart_req = tbl[i].d;
            boat_clear = tbl[i].bc;
            tick();
            chk($sformatf("vec%0d", i), int'(obs()), int'(tbl[i].exp));
        end

        // full arrival cycle from level 0
        do_reset();
        arrive_req = 1; tick(); arrive_req = 0;
        cnt = 0; lim = 0;
        while (!outer_gate_open && lim < 100) begin
            tick(); lim++;
            if (fill_valve) cnt++;
        end
        chk("arr_fill_cycles", cnt, 15);
        chk("arr_outer_open", int'(outer_gate_open), 1);
        chk("arr_lvl_entry", int'(water_level), 15);
        repeat (3) tick();
        chk("arr_outer_hold", int'(obs()), int'(12'b1000_0010_1111));
        boat_clear = 1; tick(); boat_clear = 0;
        chk("arr_outer_close", int'(outer_gate_open), 0);
        cnt = drain_valve ? 1 : 0; lim = 0;
        while (!inner_gate_open && lim < 100) begin
            tick(); lim++;
            if (drain_valve) cnt++;
        end
        chk("arr_drain_cycles", cnt, 15);
        chk("arr_inner_open", int'(inner_gate_open), 1);
        boat_clear = 1; tick(); boat_clear = 0;
        chk("arr_done", int'(obs()), 0);

        // simultaneous requests: arrival first, depart stays pending
        do_reset();
        arrive_req = 1; depart_req = 1; tick();
        arrive_req = 0; depart_req = 0;
        tick();
        ok = 1; seen_gate = 0; first_outer = 0; lim = 0;
        while (busy && lim < 200) begin
            if (!pend_depart) ok = 0;
            if (!seen_gate && (outer_gate_open || inner_gate_open)) begin
                seen_gate = 1;
                first_outer = outer_gate_open;
            end
            boat_clear = outer_gate_open || inner_gate_open;
            tick(); lim++;
        end
        boat_clear = 0;
        chk("sim_bound", int'(lim < 200), 1);
        chk("sim_pend_depart_held", int'(ok), 1);
        chk("sim_arrival_first", int'(first_outer), 1);
        chk("sim_idle_pend", int'(pend_depart), 1);
        tick();
        chk("sim_depart_start", int'({busy, pend_depart}), 2);

        // reset mid-transfer at level 7
        do_reset();
        depart_req = 1; tick(); depart_req = 0;
        lim = 0;
        while (!(fill_valve && water_level == 7) && lim < 100) begin
            boat_clear = inner_gate_open;
            tick(); lim++;
        end
        boat_clear = 0;
        chk("xfer_lvl7_reached", int'(lim < 100), 1);
        #2 rst = 1;
        #1;
        chk("xfer_async_reset", int'(obs()), 0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        tick();
        chk("xfer_no_resume", int'(obs()), 0);

`ifdef LOCK_GATE_TIMEOUT_EN
        // entry gate timeout
        do_reset();
        arrive_req = 1; tick(); arrive_req = 0;
        lim = 0;
        while (!outer_gate_open && lim < 100) begin tick(); lim++; end
        cnt = outer_gate_open ? 1 : 0; tocnt = 0; lim = 0;
        while (outer_gate_open && lim < 400) begin
            tick(); lim++;
            if (outer_gate_open) cnt++;
            if (timeout) tocnt++;
        end
        repeat (2) begin tick(); if (timeout) tocnt++; end
        chk("to_open_cycles", cnt, 255);
        chk("to_pulses", tocnt, 1);
        chk("to_state", int'({busy, water_level}), 15);
`endif

        // random run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            arrive_req = ($urandom_range(0, 9) == 0);
            depart_req = ($urandom_range(0, 9) == 0);
            boat_clear = ($urandom_range(0, 5) == 0);
            tick();
            chk("rand", int'(obs()), int'(model_out()));
            chk("rand_one_actuator",
                int'($countones(obs()[11:8]) <= 1), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
